// File: rtl/mem_ctrl_pkg.sv
// Shared constants, state encoding and byte helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

    localparam logic        RstEnable   = 1'b1;
    localparam int          DataBus     = 32;
    localparam int          InstAddrBus = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    localparam logic [1:0] LenByte = 2'd0;
    localparam logic [1:0] LenHalf = 2'd1;
    localparam logic [1:0] LenWord = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            LenByte: n = 3'd1;
            LenHalf: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and data load/store
// onto an 8-bit RAM port; every output is registered.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req_i,
    input  logic [InstAddrBus-1:0] if_addr_i,
    input  logic                   mem_req_i,
    input  logic                   mem_wr_i,
    input  logic [DataBus-1:0]     mem_addr_i,
    input  logic [1:0]             mem_len_i,
    input  logic [DataBus-1:0]     mem_wdata_i,
    input  logic [7:0]             ram_din_i,
    output logic                   ram_wr_o,
    output logic [DataBus-1:0]     ram_a_o,
    output logic [7:0]             ram_dout_o,
    output logic                   if_done_o,
    output logic [DataBus-1:0]     if_inst_o,
    output logic                   mem_done_o,
    output logic [DataBus-1:0]     mem_rdata_o,
    output logic                   stall_req_o
);

    state_t               state_r, state_s;
    owner_t               owner_r, owner_s;
    logic [2:0]           cnt_r, cnt_s;
    logic [2:0]           n_r, n_s;
    logic [DataBus-1:0]   base_r, base_s;
    logic [DataBus-1:0]   wdata_r, wdata_s;
    logic [DataBus-1:0]   buf_r, buf_s;

    logic                 ram_wr_s;
    logic [DataBus-1:0]   ram_a_s;
    logic [7:0]           ram_dout_s;
    logic                 if_done_s;
    logic [DataBus-1:0]   if_inst_s;
    logic                 mem_done_s;
    logic [DataBus-1:0]   mem_rdata_s;
    logic                 stall_s;

    // Next-state and next-output logic; cnt_r counts RAM cycles issued so far.
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        cnt_s       = cnt_r;
        n_s         = n_r;
        base_s      = base_r;
        wdata_s     = wdata_r;
        buf_s       = buf_r;
        ram_wr_s    = 1'b0;
        ram_a_s     = ZeroWord;
        ram_dout_s  = 8'h00;
        if_done_s   = 1'b0;
        mem_done_s  = 1'b0;
        if_inst_s   = if_inst_o;
        mem_rdata_s = mem_rdata_o;

        case (state_r)
            IDLE: begin
                if (mem_req_i) begin
                    owner_s = OWN_MEM;
                    base_s  = mem_addr_i;
                    n_s     = len_bytes(mem_len_i);
                    wdata_s = mem_wdata_i;
                    cnt_s   = 3'd1;
                    buf_s   = ZeroWord;
                    ram_a_s = mem_addr_i;
                    if (mem_wr_i) begin
                        state_s    = WRITE;
                        ram_wr_s   = 1'b1;
                        ram_dout_s = mem_wdata_i[7:0];
                    end else begin
                        state_s = READ;
                    end
                end else if (if_req_i) begin
                    owner_s = OWN_IF;
                    base_s  = if_addr_i;
                    n_s     = len_bytes(LenWord);
                    cnt_s   = 3'd1;
                    buf_s   = ZeroWord;
                    ram_a_s = if_addr_i;
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                cnt_s = cnt_r + 3'd1;
                if (cnt_r < n_r) begin
                    ram_a_s = base_r + 32'(cnt_r);
                end else begin
                    ram_a_s = ZeroWord;
                end
                // RAM data lags its address by one cycle, so byte k arrives when cnt_r = k+2.
                if (cnt_r >= 3'd2) begin
                    buf_s = put_byte(buf_r, 2'(cnt_r - 3'd2), ram_din_i);
                end else begin
                    buf_s = buf_r;
                end
                if (cnt_r == n_r + 3'd1) begin
                    state_s = DONE;
                    cnt_s   = 3'd0;
                    if (owner_r == OWN_MEM) begin
                        mem_done_s  = 1'b1;
                        mem_rdata_s = buf_s;
                    end else begin
                        if_done_s = 1'b1;
                        if_inst_s = buf_s;
                    end
                end else begin
                    state_s = READ;
                end
            end
            WRITE: begin
                if (cnt_r < n_r) begin
                    ram_wr_s   = 1'b1;
                    ram_a_s    = base_r + 32'(cnt_r);
                    ram_dout_s = get_byte(wdata_r, cnt_r[1:0]);
                    cnt_s      = cnt_r + 3'd1;
                end else begin
                    state_s    = DONE;
                    cnt_s      = 3'd0;
                    mem_done_s = 1'b1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 3'd0;
            end
        endcase

        // The done cycle of a data access, and the IDLE cycle right after it, never stall.
        stall_s = mem_req_i && !mem_done_s && !(state_r == DONE && owner_r == OWN_MEM);
    end

    // State, working registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_r     <= IDLE;
            owner_r     <= OWN_IF;
            cnt_r       <= 3'd0;
            n_r         <= 3'd0;
            base_r      <= ZeroWord;
            wdata_r     <= ZeroWord;
            buf_r       <= ZeroWord;
            ram_wr_o    <= 1'b0;
            ram_a_o     <= ZeroWord;
            ram_dout_o  <= 8'h00;
            if_done_o   <= 1'b0;
            if_inst_o   <= ZeroWord;
            mem_done_o  <= 1'b0;
            mem_rdata_o <= ZeroWord;
            stall_req_o <= 1'b0;
        end else begin
            state_r     <= state_s;
            owner_r     <= owner_s;
            cnt_r       <= cnt_s;
            n_r         <= n_s;
            base_r      <= base_s;
            wdata_r     <= wdata_s;
            buf_r       <= buf_s;
            ram_wr_o    <= ram_wr_s;
            ram_a_o     <= ram_a_s;
            ram_dout_o  <= ram_dout_s;
            if_done_o   <= if_done_s;
            if_inst_o   <= if_inst_s;
            mem_done_o  <= mem_done_s;
            mem_rdata_o <= mem_rdata_s;
            stall_req_o <= stall_s;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized accesses
// checked against a byte-array RAM model and the cycle rules of the controller.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [1:0]  mem_len;
    logic [31:0] mem_wdata;
    logic [7:0]  ram_din;
    logic        ram_wr;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic        if_done;
    logic [31:0] if_inst;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        stall;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr),
        .mem_req_i(mem_req), .mem_wr_i(mem_wr), .mem_addr_i(mem_addr),
        .mem_len_i(mem_len), .mem_wdata_i(mem_wdata),
        .ram_din_i(ram_din), .ram_wr_o(ram_wr), .ram_a_o(ram_a), .ram_dout_o(ram_dout),
        .if_done_o(if_done), .if_inst_o(if_inst),
        .mem_done_o(mem_done), .mem_rdata_o(mem_rdata), .stall_req_o(stall)
    );

    // RAM model: 1 KiB aliased over the address space, read data one cycle after the address.
    logic [7:0]  ram [0:1023];
    logic        fill_en = 1'b0;
    logic        poke_en = 1'b0;
    logic [31:0] poke_a  = 32'h0;
    logic [7:0]  poke_d  = 8'h0;

    always @(posedge clk) begin
        ram_din <= ram[ram_a[9:0]];
        if (fill_en) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'(i * 37 + 11);
        end else if (ram_wr) begin
            ram[ram_a[9:0]] <= ram_dout;
        end else if (poke_en) begin
            ram[poke_a[9:0]] <= poke_d;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] obs_a     [0:15];
    logic        obs_wr    [0:15];
    logic [7:0]  obs_dout  [0:15];
    logic        obs_stall [0:15];
    logic        obs_ifd   [0:15];
    logic        obs_md    [0:15];
    int          done_at;

    function automatic logic [7:0] ram_at(input logic [31:0] a);
        return ram[a[9:0]];
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] addr, input int n);
        logic [31:0] w = 32'h0;
        for (int k = 0; k < n; k++) w = w | (32'(ram_at(addr + 32'(k))) << (8 * k));
        return w;
    endfunction

    function automatic int bytes_of(input bit is_mem, input logic [1:0] len);
        if (!is_mem) return 4;
        if (len == 2'd0) return 1;
        if (len == 2'd1) return 2;
        return 4;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        poke_en = 1'b1; poke_a = a; poke_d = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // Drives one request (cycle 0) and records outputs of cycles 1.. until a done pulse.
    task automatic run_txn(input bit is_mem, input bit wr, input logic [31:0] addr,
                           input logic [1:0] len, input logic [31:0] wdata);
        done_at = -1;
        for (int c = 0; c < 16; c++) begin
            obs_a[c] = 32'h0; obs_wr[c] = 1'b0; obs_dout[c] = 8'h0;
            obs_stall[c] = 1'b0; obs_ifd[c] = 1'b0; obs_md[c] = 1'b0;
        end
        @(posedge clk); #1;
        if (is_mem) begin
            mem_req = 1'b1; mem_wr = wr; mem_addr = addr; mem_len = len; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int c = 1; c <= 12 && done_at < 0; c++) begin
            @(posedge clk); #1;
            obs_a[c] = ram_a; obs_wr[c] = ram_wr; obs_dout[c] = ram_dout;
            obs_stall[c] = stall; obs_ifd[c] = if_done; obs_md[c] = mem_done;
            if (if_done || mem_done) done_at = c;
        end
        mem_req = 1'b0; if_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; fill_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        fill_en = 1'b0;
        n_checks++;
        if ({ram_wr, ram_a, ram_dout} !== 41'h0) begin
            n_fail++; $display("FAIL reset_ram_port got %h want 0", {ram_wr, ram_a, ram_dout});
        end
        n_checks++;
        if ({if_done, mem_done, stall} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags got %b want 000", {if_done, mem_done, stall});
        end
        n_checks++;
        if ({if_inst, mem_rdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_data got %h want 0", {if_inst, mem_rdata});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch();
        poke(32'h1000, 8'h13); poke(32'h1001, 8'h00); poke(32'h1002, 8'h00); poke(32'h1003, 8'h00);
        run_txn(1'b0, 1'b0, 32'h1000, 2'd0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (obs_a[k+1] !== 32'h1000 + 32'(k)) begin
                n_fail++; $display("FAIL fetch_addr c%0d got %h want %h", k + 1, obs_a[k+1], 32'h1000 + 32'(k));
            end
        end
        n_checks++;
        if (done_at !== 6) begin n_fail++; $display("FAIL fetch_done_cycle got %0d want 6", done_at); end
        n_checks++;
        if (if_inst !== 32'h0000_0013) begin n_fail++; $display("FAIL fetch_inst got %h want 00000013", if_inst); end
    endtask

    task automatic test_store();
        logic [31:0] w = 32'hDEAD_BEEF;
        run_txn(1'b1, 1'b1, 32'h20, 2'd2, w);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({obs_wr[k+1], obs_a[k+1], obs_dout[k+1]} !== {1'b1, 32'h20 + 32'(k), 8'(w >> (8 * k))}) begin
                n_fail++; $display("FAIL store_beat c%0d got wr=%b a=%h d=%h", k + 1, obs_wr[k+1], obs_a[k+1], obs_dout[k+1]);
            end
        end
        n_checks++;
        if (done_at !== 5) begin n_fail++; $display("FAIL store_done_cycle got %0d want 5", done_at); end
        n_checks++;
        if (model_word(32'h20, 4) !== w) begin
            n_fail++; $display("FAIL store_ram got %h want %h", model_word(32'h20, 4), w);
        end
    endtask

    task automatic test_load();
        poke(32'h30, 8'h80);
        run_txn(1'b1, 1'b0, 32'h30, 2'd0, 32'h0);
        n_checks++;
        if (done_at !== 3) begin n_fail++; $display("FAIL loadb_done_cycle got %0d want 3", done_at); end
        n_checks++;
        if (mem_rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL loadb_data got %h want 00000080", mem_rdata); end
        poke(32'h31, 8'h34); poke(32'h32, 8'h12);
        run_txn(1'b1, 1'b0, 32'h31, 2'd1, 32'h0);
        n_checks++;
        if (mem_rdata !== 32'h0000_1234) begin n_fail++; $display("FAIL loadh_data got %h want 00001234", mem_rdata); end
    endtask

    task automatic test_wrap();
        logic [31:0] expw = model_word(32'hFFFF_FFFE, 4);
        run_txn(1'b1, 1'b0, 32'hFFFF_FFFE, 2'd3, 32'h0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (obs_a[k+1] !== 32'hFFFF_FFFE + 32'(k)) begin
                n_fail++; $display("FAIL wrap_addr c%0d got %h want %h", k + 1, obs_a[k+1], 32'hFFFF_FFFE + 32'(k));
            end
        end
        n_checks++;
        if (mem_rdata !== expw) begin n_fail++; $display("FAIL wrap_data got %h want %h", mem_rdata, expw); end
    endtask

    task automatic test_priority();
        int md_at = -1, id_at = -1;
        logic [31:0] a5 = 32'h0;
        logic st2 = 1'b0, st3 = 1'b1;
        logic [31:0] exp_inst = model_word(32'h40, 4);
        logic [31:0] exp_data = model_word(32'h30, 1);
        @(posedge clk); #1;
        mem_req = 1'b1; mem_wr = 1'b0; mem_addr = 32'h30; mem_len = 2'd0;
        if_req = 1'b1; if_addr = 32'h40;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (c == 2) st2 = stall;
            if (c == 3) st3 = stall;
            if (c == 5) a5 = ram_a;
            if (mem_done && md_at < 0) begin md_at = c; mem_req = 1'b0; end
            if (if_done && id_at < 0) begin id_at = c; if_req = 1'b0; end
        end
        mem_req = 1'b0; if_req = 1'b0;
        n_checks++;
        if (md_at !== 3) begin n_fail++; $display("FAIL prio_mem_done got %0d want 3", md_at); end
        n_checks++;
        if (id_at !== 10) begin n_fail++; $display("FAIL prio_if_done got %0d want 10", id_at); end
        n_checks++;
        if (a5 !== 32'h40) begin n_fail++; $display("FAIL prio_fetch_start got %h want 00000040", a5); end
        n_checks++;
        if ({st2, st3} !== 2'b10) begin n_fail++; $display("FAIL prio_stall got %b want 10", {st2, st3}); end
        n_checks++;
        if ({if_inst, mem_rdata} !== {exp_inst, exp_data}) begin
            n_fail++; $display("FAIL prio_data got %h/%h want %h/%h", if_inst, mem_rdata, exp_inst, exp_data);
        end
    endtask

    task automatic test_hold();
        logic [31:0] inst0, data0;
        run_txn(1'b0, 1'b0, 32'h100, 2'd0, 32'h0);
        inst0 = if_inst;
        run_txn(1'b1, 1'b0, 32'h200, 2'd2, 32'h0);
        data0 = mem_rdata;
        n_checks++;
        if (if_inst !== inst0) begin n_fail++; $display("FAIL hold_inst got %h want %h", if_inst, inst0); end
        run_txn(1'b1, 1'b1, 32'h300, 2'd1, 32'h5555_AAAA);
        n_checks++;
        if (mem_rdata !== data0) begin n_fail++; $display("FAIL hold_rdata got %h want %h", mem_rdata, data0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] old52 = ram_at(32'h52);
        logic       bad = 1'b0;
        @(posedge clk); #1;
        mem_req = 1'b1; mem_wr = 1'b1; mem_addr = 32'h50; mem_len = 2'd2; mem_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_req = 1'b0;
        n_checks++;
        if ({ram_wr, ram_a, ram_dout, if_done, mem_done, stall, if_inst, mem_rdata} !== 108'h0) begin
            n_fail++; $display("FAIL rstmid_outputs got wr=%b a=%h inst=%h rdata=%h", ram_wr, ram_a, if_inst, mem_rdata);
        end
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (ram_wr || mem_done || if_done) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet got activity=%b want 0", bad); end
        n_checks++;
        if ({ram_at(32'h50), ram_at(32'h51), ram_at(32'h52)} !== {8'h0D, 8'hF0, old52}) begin
            n_fail++; $display("FAIL rstmid_ram got %h%h%h want 0DF0%h", ram_at(32'h50), ram_at(32'h51), ram_at(32'h52), old52);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            bit          is_mem = ($urandom_range(0, 2) != 0);
            bit          wr     = is_mem && ($urandom_range(0, 1) == 1);
            logic [1:0]  len    = 2'($urandom_range(0, 3));
            logic [31:0] addr   = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : 32'($urandom);
            logic [31:0] wdata  = 32'($urandom);
            int          n      = bytes_of(is_mem, len);
            int          exp_done = wr ? n + 1 : n + 2;
            logic [31:0] exp_rd = model_word(addr, n);
            run_txn(is_mem, wr, addr, len, wdata);
            for (int k = 0; k < n; k++) begin
                n_checks++;
                if (obs_a[k+1] !== addr + 32'(k) || obs_wr[k+1] !== wr ||
                    obs_dout[k+1] !== (wr ? 8'(wdata >> (8 * k)) : 8'h00)) begin
                    n_fail++; $display("FAIL rand%0d_beat%0d got a=%h wr=%b d=%h want a=%h wr=%b", t, k,
                                       obs_a[k+1], obs_wr[k+1], obs_dout[k+1], addr + 32'(k), wr);
                end
            end
            n_checks++;
            if (done_at !== exp_done) begin
                n_fail++; $display("FAIL rand%0d_done_cycle got %0d want %0d", t, done_at, exp_done);
            end else if ({obs_md[done_at], obs_ifd[done_at]} !== {is_mem, !is_mem}) begin
                n_fail++; $display("FAIL rand%0d_done_owner got md=%b ifd=%b", t, obs_md[done_at], obs_ifd[done_at]);
            end
            if (is_mem) begin
                for (int c = 1; c <= exp_done; c++) begin
                    n_checks++;
                    if (obs_stall[c] !== (c != exp_done)) begin
                        n_fail++; $display("FAIL rand%0d_stall c%0d got %b want %b", t, c, obs_stall[c], c != exp_done);
                    end
                end
            end
            n_checks++;
            if (wr) begin
                if (model_word(addr, n) !== (n == 4 ? wdata : (wdata & ((32'h1 << (8 * n)) - 32'h1)))) begin
                    n_fail++; $display("FAIL rand%0d_ram got %h wdata %h", t, model_word(addr, n), wdata);
                end
            end else if ((is_mem ? mem_rdata : if_inst) !== exp_rd) begin
                n_fail++; $display("FAIL rand%0d_rdata got %h want %h", t, is_mem ? mem_rdata : if_inst, exp_rd);
            end
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
        mem_req = 1'b0; mem_wr = 1'b0; mem_addr = 32'h0; mem_len = 2'd0; mem_wdata = 32'h0;
        test_reset();
        test_fetch();
        test_store();
        test_load();
        test_wrap();
        test_priority();
        test_hold();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
